program_fetch_unit: RTL and testbench
=====================================

PROGRAM_FETCH_UNIT -- requirements
Module: program_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, bits per instruction word.
REQ-002 Parameter DEPTH, default 10, instruction words held (2..256).
REQ-003 Parameter AW, default 4, pc width; SHALL satisfy 2**AW >= DEPTH.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  capture program_addr_array into the internal store.
REQ-007 program_addr_array  input  WIDTH*DEPTH  flattened program; word i = bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-008 start  input  1  begin fetching from pc = 0.
REQ-009 jump_en  input  1  redirect pc to jump_addr.
REQ-010 jump_addr  input  AW  jump target.
REQ-011 instr_ready  input  1  consumer (control unit) accepts instr.
REQ-012 instr  output  WIDTH  current instruction word, mem[pc].
REQ-013 instr_valid  output  1  instr is a valid non-zero word.
REQ-014 pc  output  AW  current fetch address.
REQ-015 busy  output  1  high in RUN.
REQ-016 halted  output  1  high in HALT.
REQ-017 halt_cause  output  2  00 none, 01 zero sentinel, 10 end of memory, 11 bad jump.
REQ-018 instr_count  output  16  accepted transfers since start; saturates at 16'hFFFF.

Function
REQ-019 States: IDLE, RUN, HALT; encoding is free.
REQ-020 load in IDLE or HALT SHALL copy all DEPTH words into the store on the same edge; load in RUN SHALL be ignored.
REQ-021 A start that coincides with a load SHALL fetch the newly loaded words.
REQ-022 start in IDLE or HALT: next state RUN, pc = 0, instr_count = 0, halt_cause = 00.
REQ-023 start in RUN SHALL be ignored.
REQ-024 instr SHALL equal mem[pc] combinationally in every state.
REQ-025 instr_valid SHALL be high only when state = RUN and mem[pc] != 0.
REQ-026 A transfer occurs on an edge where instr_valid and instr_ready are both high.
REQ-027 On a transfer, instr_count SHALL increment, saturating.
REQ-028 On a transfer with no jump: if pc = DEPTH-1, next state HALT with cause 10 and pc held; otherwise pc = pc+1.
REQ-029 In RUN with mem[pc] = 0: next state HALT, cause 01, pc held at the sentinel address, no transfer counted.
REQ-030 jump_en in RUN with jump_addr < DEPTH SHALL set pc = jump_addr, taking priority over increment and end-of-memory halt.
REQ-031 A transfer on the same edge as a jump SHALL still be counted.
REQ-032 jump_en in RUN with jump_addr >= DEPTH: next state HALT, cause 11, pc held; a same-edge transfer is still counted.
REQ-033 jump_en in IDLE or HALT SHALL be ignored.
REQ-034 With instr_valid high and instr_ready low, pc, instr and state SHALL hold; no timeout.
REQ-035 busy = (state == RUN); halted = (state == HALT).

Reset
REQ-036 rst high SHALL immediately force: state IDLE, pc 0, instr_count 0, halt_cause 00, busy 0, halted 0, instr_valid 0.
REQ-037 Every store word SHALL reset to 0.
REQ-038 Reset asserted mid-RUN SHALL abort fetch with no further transfers; after release, start is required to resume.

Verification
REQ-039 Load words 11,22,33,0,...; start; ready held high -> instr 11,22,33 on consecutive cycles, then HALT, cause 01, pc 3, instr_count 3.
REQ-040 Load DEPTH non-zero words; start; ready high -> DEPTH transfers, then HALT, cause 10, pc = DEPTH-1.
REQ-041 Toggle ready 1,0,0,1 during RUN -> pc and instr held while ready low; no transfer lost or duplicated.
REQ-042 At pc 2 with ready high, jump_en with jump_addr 7 -> word 2 counted, next pc 7; jump_addr 12 (DEPTH 10) -> HALT, cause 11.
REQ-043 Load attempted during RUN -> store unchanged; load plus start in HALT -> new program fetched from pc 0.
REQ-044 rst pulsed asynchronously mid-RUN -> outputs reach reset values before the next clk edge; store reads 0.

Source files
------------

// File: rtl/program_fetch_unit.sv
// rtl/program_fetch_unit.sv - instruction store and fetch sequencer with zero-sentinel halt
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   load                capture program_addr_array into the store (ignored in RUN)
//   program_addr_array  flattened program, word i at [(i+1)*WIDTH-1 : i*WIDTH]
//   start               begin fetching at pc 0 (ignored in RUN)
//   jump_en, jump_addr  redirect pc while running
//   instr_ready         consumer accepts instr
//   instr, instr_valid  current word mem[pc] and its qualifier
//   pc                  current fetch address
//   busy, halted        RUN / HALT state flags
//   halt_cause          00 none, 01 zero sentinel, 10 end of memory, 11 bad jump
//   instr_count         accepted transfers since start, saturating
module program_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] program_addr_array,
  input  logic                   start,
  input  logic                   jump_en,
  input  logic [AW-1:0]          jump_addr,
  input  logic                   instr_ready,
  output logic [WIDTH-1:0]       instr,
  output logic                   instr_valid,
  output logic [AW-1:0]          pc,
  output logic                   busy,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [15:0]            instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ZERO = 2'b01;
  localparam logic [1:0] CAUSE_END  = 2'b10;
  localparam logic [1:0] CAUSE_JUMP = 2'b11;

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t        state, state_n;
  logic [AW-1:0] pc_n;
  logic [1:0]    cause_n;
  logic [15:0]   count_n;
  logic          xfer;
  logic          jump_ok;

  // Store: loads are only accepted outside RUN so a running program never
  // changes underneath the fetch pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load && state != ST_RUN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= program_addr_array[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      halt_cause  <= CAUSE_NONE;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      halt_cause  <= cause_n;
      instr_count <= count_n;
    end
  end

  assign instr       = mem[pc];
  assign instr_valid = (state == ST_RUN) && (instr != '0);
  assign busy        = (state == ST_RUN);
  assign halted      = (state == ST_HALT);
  assign xfer        = instr_valid && instr_ready;
  assign jump_ok     = 32'(jump_addr) < DEPTH;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cause_n = halt_cause;
    count_n = instr_count;

    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_n = ST_RUN;
          pc_n    = '0;
          cause_n = CAUSE_NONE;
          count_n = '0;
        end
      end

      ST_RUN: begin
        if (instr == '0) begin
          // Zero word is the end-of-program marker: stop on it, nothing counted.
          state_n = ST_HALT;
          cause_n = CAUSE_ZERO;
        end else begin
          if (xfer && instr_count != 16'hFFFF) count_n = instr_count + 16'd1;

          // A jump redirects even without a transfer and overrides both
          // the increment and the end-of-memory stop.
          if (jump_en) begin
            if (jump_ok) begin
              pc_n = jump_addr;
            end else begin
              state_n = ST_HALT;
              cause_n = CAUSE_JUMP;
            end
          end else if (xfer) begin
            if (pc == LAST_PC) begin
              state_n = ST_HALT;
              cause_n = CAUSE_END;
            end else begin
              pc_n = pc + AW'(1);
            end
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        pc_n    = '0;
        cause_n = CAUSE_NONE;
        count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_program_fetch_unit.sv
// tb/tb_program_fetch_unit.sv - table-driven self-checking bench for program_fetch_unit
module tb_program_fetch_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load;
  logic [WIDTH*DEPTH-1:0] program_addr_array;
  logic                   start;
  logic                   jump_en;
  logic [AW-1:0]          jump_addr;
  logic                   instr_ready;
  logic [WIDTH-1:0]       instr;
  logic                   instr_valid;
  logic [AW-1:0]          pc;
  logic                   busy;
  logic                   halted;
  logic [1:0]             halt_cause;
  logic [15:0]            instr_count;

  program_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .load               (load),
    .program_addr_array (program_addr_array),
    .start              (start),
    .jump_en            (jump_en),
    .jump_addr          (jump_addr),
    .instr_ready        (instr_ready),
    .instr              (instr),
    .instr_valid        (instr_valid),
    .pc                 (pc),
    .busy               (busy),
    .halted             (halted),
    .halt_cause         (halt_cause),
    .instr_count        (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ld;
    logic          sel;
    logic          st;
    logic          je;
    logic [AW-1:0] ja;
    logic          rdy;
    logic [31:0]   e_instr;
    logic          e_valid;
    logic [AW-1:0] e_pc;
    logic [1:0]    e_state;
    logic [1:0]    e_cause;
    logic [15:0]   e_cnt;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH*DEPTH-1:0] prog_a;
  logic [WIDTH*DEPTH-1:0] prog_b;
  vec_t vecs[$];

  function automatic logic [31:0] pb(input int i);
    return 32'h1000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic ld, input logic sel, input logic st,
                              input logic je, input logic [AW-1:0] ja, input logic rdy,
                              input logic [31:0] ei, input logic ev, input logic [AW-1:0] ep,
                              input logic [1:0] es, input logic [1:0] ec, input logic [15:0] en);
    vec_t v;
    v.ld = ld; v.sel = sel; v.st = st; v.je = je; v.ja = ja; v.rdy = rdy;
    v.e_instr = ei; v.e_valid = ev; v.e_pc = ep; v.e_state = es; v.e_cause = ec; v.e_cnt = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] ei, input logic ev,
                               input logic [AW-1:0] ep, input logic [1:0] es,
                               input logic [1:0] ec, input logic [15:0] en);
    check({tag, ".instr"},  instr, ei);
    check({tag, ".valid"},  32'(instr_valid), 32'(ev));
    check({tag, ".pc"},     32'(pc), 32'(ep));
    check({tag, ".busy"},   32'(busy), 32'(es == S_RUN));
    check({tag, ".halted"}, 32'(halted), 32'(es == S_HALT));
    check({tag, ".cause"},  32'(halt_cause), 32'(ec));
    check({tag, ".count"},  32'(instr_count), 32'(en));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    load = 1'b0; start = 1'b0; jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      prog_a[i*WIDTH +: WIDTH] = (i == 0) ? 32'd11 : (i == 1) ? 32'd22 : (i == 2) ? 32'd33 : 32'd0;
      prog_b[i*WIDTH +: WIDTH] = pb(i);
    end

    // Program A: 11,22,33 then zero sentinel.
    vecs.push_back(mk(1,0,1,0,0,1, 32'd11, 1, 0, S_RUN,  0, 0));
    vecs.push_back(mk(0,0,0,0,0,1, 32'd22, 1, 1, S_RUN,  0, 1));
    vecs.push_back(mk(0,0,0,0,0,1, 32'd33, 1, 2, S_RUN,  0, 2));
    vecs.push_back(mk(0,0,0,0,0,1, 32'd0,  0, 3, S_RUN,  0, 3));
    vecs.push_back(mk(0,0,0,0,0,1, 32'd0,  0, 3, S_HALT, 1, 3));
    // Load + start from HALT, then ready 1,0,0,1.
    vecs.push_back(mk(1,1,1,0,0,0, pb(0),  1, 0, S_RUN,  0, 0));
    vecs.push_back(mk(0,0,0,0,0,1, pb(1),  1, 1, S_RUN,  0, 1));
    vecs.push_back(mk(0,0,0,0,0,0, pb(1),  1, 1, S_RUN,  0, 1));
    vecs.push_back(mk(0,0,0,0,0,0, pb(1),  1, 1, S_RUN,  0, 1));
    vecs.push_back(mk(0,0,0,0,0,1, pb(2),  1, 2, S_RUN,  0, 2));
    // Jump to 7 with a same-edge transfer at pc 2.
    vecs.push_back(mk(0,0,0,1,7,1, pb(7),  1, 7, S_RUN,  0, 3));
    // Load and start during RUN are ignored.
    vecs.push_back(mk(1,0,1,0,0,0, pb(7),  1, 7, S_RUN,  0, 3));
    vecs.push_back(mk(0,0,0,0,0,1, pb(8),  1, 8, S_RUN,  0, 4));
    vecs.push_back(mk(0,0,0,0,0,1, pb(9),  1, 9, S_RUN,  0, 5));
    // Transfer at last address -> end-of-memory halt.
    vecs.push_back(mk(0,0,0,0,0,1, pb(9),  0, 9, S_HALT, 2, 6));
    // Jump in HALT ignored.
    vecs.push_back(mk(0,0,0,1,2,1, pb(9),  0, 9, S_HALT, 2, 6));
    // Restart without load keeps program B.
    vecs.push_back(mk(0,0,1,0,0,1, pb(0),  1, 0, S_RUN,  0, 0));
    // Out-of-range jump with same-edge transfer.
    vecs.push_back(mk(0,0,0,1,12,1, pb(0), 0, 0, S_HALT, 3, 1));

    rst = 1'b1;
    program_addr_array = '0;
    idle_inputs();
    #2;
    check_outputs("reset", 32'd0, 0, 0, S_IDLE, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    check_outputs("post_reset", 32'd0, 0, 0, S_IDLE, 0, 0);

    foreach (vecs[k]) begin
      load               = vecs[k].ld;
      program_addr_array = vecs[k].sel ? prog_b : prog_a;
      start              = vecs[k].st;
      jump_en            = vecs[k].je;
      jump_addr          = vecs[k].ja;
      instr_ready        = vecs[k].rdy;
      tick();
      check_outputs($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_valid,
                    vecs[k].e_pc, vecs[k].e_state, vecs[k].e_cause, vecs[k].e_cnt);
    end

    // Full run through all DEPTH non-zero words.
    idle_inputs();
    load = 1'b1; program_addr_array = prog_b; start = 1'b1; instr_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("full.instr%0d", i), instr, pb(i));
      check($sformatf("full.valid%0d", i), 32'(instr_valid), 32'd1);
      tick();
      check($sformatf("full.count%0d", i), 32'(instr_count), 32'(i + 1));
    end
    check_outputs("full_end", pb(DEPTH - 1), 0, AW'(DEPTH - 1), S_HALT, 2, 16'(DEPTH));

    // Asynchronous reset mid-RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid.pc", 32'(pc), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 32'd0, 0, 0, S_IDLE, 0, 0);
    rst = 1'b0;
    tick();
    check_outputs("no_resume", 32'd0, 0, 0, S_IDLE, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
